// File: rtl/adder_arbiter.sv
// -----------------------------------------------------------------------------
// adder_arbiter
//
// Round-robin arbiter that shares one combinational `adder` among NUM_REQ
// requesters. The granted operand pair is added and the WIDTH+1-bit sum is
// registered into a single-entry output slot tagged with the requester index.
// One addition per cycle is sustained while the consumer is not stalling.
//
// Optional feature: define ADDER_ARB_STATS_EN to add saturating statistics
// outputs stat_grants / stat_stalls. Without it those ports do not exist.
//
// Ports:
//   clk         sole clock, rising edge
//   rst         asynchronous, active-high reset
//   req_valid   [NUM_REQ]          requester i holds an operand pair
//   req_ready   [NUM_REQ]          pair i accepted this cycle (one-hot or zero)
//   req_a/b     [NUM_REQ*WIDTH]    operands, requester i at [i*WIDTH +: WIDTH]
//   resp_valid                     output slot holds a result
//   resp_ready                     consumer takes the result this cycle
//   resp_sum    [WIDTH+1]          registered a+b including carry
//   resp_id     [ID_W]             requester that produced resp_sum
//   stat_grants [32]  (stats only) total grants, saturating
//   stat_stalls [32]  (stats only) cycles a request waited on a full slot
// -----------------------------------------------------------------------------

// Shared combinational adder: zero-extends both operands so the carry is kept.
module adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   sum
);
  assign sum = {1'b0, a} + {1'b0, b};
endmodule

module adder_arbiter #(
  parameter  int WIDTH   = 8,
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH:0]           resp_sum,
  output logic [ID_W-1:0]          resp_id
`ifdef ADDER_ARB_STATS_EN
  ,
  output logic [31:0]              stat_grants,
  output logic [31:0]              stat_stalls
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  slot_state_t      state_q, state_d;
  logic [ID_W-1:0]  ptr_q;
  logic [ID_W-1:0]  ptr_next;
  logic             slot_free;
  logic             grant_found;
  logic [ID_W-1:0]  grant_idx;
  logic [ID_W-1:0]  scan_idx;
  logic             grant;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH:0]   sum_sel;

  // A full slot that is being drained this cycle can be refilled in the same
  // cycle, which is what keeps back-to-back throughput at one per cycle.
  assign slot_free  = (state_q == EMPTY) || resp_ready;
  assign resp_valid = (state_q == FULL);
  assign grant      = slot_free && grant_found;

  // Round-robin search. Scanning offsets from high to low lets the closest
  // requester to ptr_q overwrite any farther one, so the lowest offset wins.
  // Only req_valid and ptr_q feed this search, never the operands.
  // NOTE: every signal written in an always_comb gets a default first so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan_idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  // One-hot ready and operand mux use constant slice indices only.
  always_comb begin
    req_ready = '0;
    a_sel     = '0;
    b_sel     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_idx == ID_W'(k)) begin
        req_ready[k] = grant;
        a_sel        = req_a[k*WIDTH +: WIDTH];
        b_sel        = req_b[k*WIDTH +: WIDTH];
      end
    end
  end

  adder #(.WIDTH(WIDTH)) u_adder (
    .a   (a_sel),
    .b   (b_sel),
    .sum (sum_sel)
  );

  // Explicit wrap so non-power-of-two NUM_REQ rotates correctly.
  assign ptr_next = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;

  // Slot state: a grant always fills; otherwise a taken result empties.
  always_comb begin
    state_d = state_q;
    if (grant) begin
      state_d = FULL;
    end else if (resp_ready) begin
      state_d = EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        ptr_q <= ptr_next;
      end
    end
  end

  // Payload only moves on a grant; a drain without refill leaves it as is.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_sum <= '0;
      resp_id  <= '0;
    end else if (grant) begin
      resp_sum <= sum_sel;
      resp_id  <= grant_idx;
    end
  end

`ifdef ADDER_ARB_STATS_EN
  // Saturating counters: hold at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_grants <= '0;
      stat_stalls <= '0;
    end else begin
      if (grant && (stat_grants != '1)) begin
        stat_grants <= stat_grants + 32'd1;
      end
      if ((|req_valid) && (state_q == FULL) && !resp_ready &&
          (stat_stalls != '1)) begin
        stat_stalls <= stat_stalls + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_adder_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_arbiter
//
// Self-checking bench for adder_arbiter (WIDTH=8, NUM_REQ=4). Directed
// scenarios compare against hand-derived constants; the random scenario
// compares every cycle against a transaction-level reference model of the
// arbiter (rotating priority, one-entry slot, per-requester result queues).
// Inputs change 1 ns after the rising edge; req_ready is sampled 1 ns later
// and registered outputs are sampled 1 ns after the following edge.
// -----------------------------------------------------------------------------
module tb_adder_arbiter;

  localparam int WIDTH   = 8;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     resp_valid;
  logic                     resp_ready;
  logic [WIDTH:0]           resp_sum;
  logic [ID_W-1:0]          resp_id;
`ifdef ADDER_ARB_STATS_EN
  logic [31:0]              stat_grants;
  logic [31:0]              stat_stalls;
`endif

  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];

  int checks = 0;
  int errors = 0;

  adder_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_sum   (resp_sum),
    .resp_id    (resp_id)
`ifdef ADDER_ARB_STATS_EN
    ,
    .stat_grants(stat_grants),
    .stat_stalls(stat_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_a[i*WIDTH +: WIDTH] = a_arr[i];
      req_b[i*WIDTH +: WIDTH] = b_arr[i];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Short asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", resp_valid); end
    checks++; if (resp_sum !== 9'h000) begin errors++; $display("FAIL reset_sum got %h exp 000", resp_sum); end
    checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", resp_id); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready got %b exp 0000", req_ready); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    a_arr[0] = 8'h12; b_arr[0] = 8'h34;
    req_valid = 4'b0001; resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b exp 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b exp 1", resp_valid); end
    checks++; if (resp_sum !== 9'h046) begin errors++; $display("FAIL single_sum got %h exp 046", resp_sum); end
    checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL single_id got %0d exp 0", resp_id); end
    tick();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL single_drain got %b exp 0", resp_valid); end
    checks++; if (resp_sum !== 9'h046) begin errors++; $display("FAIL single_hold_sum got %h exp 046", resp_sum); end
  endtask

  task automatic test_overflow();
    // ptr is 1 after the single grant; scan 1,2 picks requester 2.
    a_arr[2] = 8'hFF; b_arr[2] = 8'hFF;
    req_valid = 4'b0100; resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL ovf_ready got %b exp 0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++; if (resp_sum !== 9'h1FE) begin errors++; $display("FAIL ovf_sum got %h exp 1fe", resp_sum); end
    checks++; if (resp_id !== 2'd2) begin errors++; $display("FAIL ovf_id got %0d exp 2", resp_id); end
    tick();
  endtask

  task automatic test_round_robin();
    logic [WIDTH:0] exp_sum;
    pulse_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = 8'(i + 1);
      b_arr[i] = 8'(16 * i + 200);
    end
    req_valid = 4'b1111; resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (req_ready !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", k, req_ready, 4'(1 << (k % 4))); end
      tick();
      exp_sum = 9'((k % 4) + 1) + 9'(16 * (k % 4) + 200);
      checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL rr_valid[%0d] got %b exp 1", k, resp_valid); end
      checks++; if (resp_id !== 2'(k % 4)) begin errors++; $display("FAIL rr_id[%0d] got %0d exp %0d", k, resp_id, k % 4); end
      checks++; if (resp_sum !== exp_sum) begin errors++; $display("FAIL rr_sum[%0d] got %h exp %h", k, resp_sum, exp_sum); end
    end
    req_valid = 4'b0000;
    tick();
  endtask

  task automatic test_back_pressure();
    // ptr is 1: requester 0 alone is granted after wrapping, ptr stays 1.
    a_arr[0] = 8'h0A; b_arr[0] = 8'h05;
    req_valid = 4'b0001; resp_ready = 1'b1;
    tick();
    a_arr[1] = 8'h80; b_arr[1] = 8'h81;
    a_arr[2] = 8'h33; b_arr[2] = 8'h44;
    req_valid = 4'b0110; resp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready[%0d] got %b exp 0000", k, req_ready); end
      tick();
      checks++; if (resp_valid !== 1'b1 || resp_sum !== 9'h00F || resp_id !== 2'd0) begin
        errors++; $display("FAIL bp_hold[%0d] got v=%b sum=%h id=%0d exp v=1 sum=00f id=0", k, resp_valid, resp_sum, resp_id);
      end
    end
    resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release_ready got %b exp 0010", req_ready); end
    tick();
    req_valid = 4'b0100;
    checks++; if (resp_sum !== 9'h101 || resp_id !== 2'd1) begin errors++; $display("FAIL bp_release_result got sum=%h id=%0d exp sum=101 id=1", resp_sum, resp_id); end
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_next_ready got %b exp 0100", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++; if (resp_sum !== 9'h077 || resp_id !== 2'd2) begin errors++; $display("FAIL bp_next_result got sum=%h id=%0d exp sum=077 id=2", resp_sum, resp_id); end
    tick();
  endtask

  task automatic test_reset_mid();
    // ptr is 3 after granting requester 2.
    a_arr[3] = 8'h21; b_arr[3] = 8'h43;
    req_valid = 4'b1000; resp_ready = 1'b1;
    tick();
    req_valid = 4'b0000; resp_ready = 1'b0;
    #1;
    checks++; if (resp_valid !== 1'b1 || resp_id !== 2'd3 || resp_sum !== 9'h064) begin
      errors++; $display("FAIL mid_full got v=%b sum=%h id=%0d exp v=1 sum=064 id=3", resp_valid, resp_sum, resp_id);
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (resp_valid !== 1'b0 || resp_sum !== 9'h000 || resp_id !== 2'd0) begin
      errors++; $display("FAIL mid_async got v=%b sum=%h id=%0d exp all 0", resp_valid, resp_sum, resp_id);
    end
    tick();
    rst = 1'b0;
    req_valid = 4'b1111; resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_ready got %b exp 0001", req_ready); end
    tick();
    req_valid = 4'b0000;
    checks++; if (resp_id !== 2'd0 || resp_valid !== 1'b1) begin errors++; $display("FAIL mid_first_id got v=%b id=%0d exp v=1 id=0", resp_valid, resp_id); end
    tick();
  endtask

  task automatic test_random();
    logic [NUM_REQ-1:0] pend;
    logic [NUM_REQ-1:0] exp_ready;
    logic               m_valid;
    logic [WIDTH:0]     m_sum;
    int                 m_id;
    int                 m_ptr;
    int                 g;
    int                 accepted;
    int                 stalls;
    logic [WIDTH:0]     sb_q [NUM_REQ][$];
    logic [WIDTH:0]     front;

    pulse_reset();
    pend = '0; m_valid = 1'b0; m_sum = '0; m_id = 0; m_ptr = 0;
    accepted = 0; stalls = 0;

    for (int n = 0; n < 1000; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i]  = 1'b1;
          a_arr[i] = 8'($urandom);
          b_arr[i] = 8'($urandom);
        end
      end
      req_valid  = pend;
      resp_ready = ($urandom_range(0, 3) != 0);
      #1;

      // Reference: grant goes to the nearest pending requester at or after
      // the rotating pointer, but only if the slot can take a new result.
      g = -1;
      if (!m_valid || resp_ready) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (g < 0 && pend[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
        end
      end
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;

      checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", n, req_ready, exp_ready); end
      checks++; if ($countones(req_ready) > 1) begin errors++; $display("FAIL rnd_onehot[%0d] got %b exp at most one bit", n, req_ready); end
      checks++; if (resp_valid !== m_valid) begin errors++; $display("FAIL rnd_valid[%0d] got %b exp %b", n, resp_valid, m_valid); end

      if (m_valid && resp_ready) begin
        checks++; if (resp_id !== 2'(m_id) || resp_sum !== m_sum) begin
          errors++; $display("FAIL rnd_result[%0d] got sum=%h id=%0d exp sum=%h id=%0d", n, resp_sum, resp_id, m_sum, m_id);
        end
        front = 'x;
        if (sb_q[m_id].size() > 0) front = sb_q[m_id].pop_front();
        checks++; if (resp_sum !== front) begin errors++; $display("FAIL rnd_order[%0d] req %0d got %h exp %h", n, m_id, resp_sum, front); end
      end

      if ((|pend) && m_valid && !resp_ready) stalls++;

      if (g >= 0) begin
        m_valid = 1'b1;
        m_sum   = 9'(a_arr[g]) + 9'(b_arr[g]);
        m_id    = g;
        m_ptr   = (g + 1) % NUM_REQ;
        sb_q[g].push_back(m_sum);
        pend[g] = 1'b0;
        accepted++;
      end else if (resp_ready) begin
        m_valid = 1'b0;
      end
      tick();
    end

`ifdef ADDER_ARB_STATS_EN
    checks++; if (stat_grants !== 32'(accepted)) begin errors++; $display("FAIL stat_grants got %0d exp %0d", stat_grants, accepted); end
    checks++; if (stat_stalls !== 32'(stalls)) begin errors++; $display("FAIL stat_stalls got %0d exp %0d", stat_stalls, stalls); end
`endif

    req_valid  = '0;
    resp_ready = 1'b1;
    tick();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rnd_final_drain got %b exp 0", resp_valid); end
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    resp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end
    test_reset();
    test_single();
    test_overflow();
    test_round_robin();
    test_back_pressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter that shares one `adder` instance among `NUM_REQ` requesters. Each requester presents operand pairs over a valid/ready handshake. The granted pair goes through the shared combinational adder, and the `WIDTH+1`-bit sum is registered into a single-entry output slot tagged with the requester index. It sits between requester-side datapath clients and the shared adder resource and sustains one addition per cycle when the output is not back-pressured.

## Interface
- `WIDTH`, 8, operand width; sum is `WIDTH+1` bits
- `NUM_REQ`, 4, number of requesters; legal range 2..16
- `ID_W`, `$clog2(NUM_REQ)`, width of the requester tag (localparam)

- `clk`  in  1  sole clock; all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  `NUM_REQ`  bit i: requester i holds a pair
- `req_ready`  out  `NUM_REQ`  bit i: pair i accepted this cycle; at most one bit set
- `req_a`  in  `NUM_REQ*WIDTH`  operand a; requester i at `[i*WIDTH +: WIDTH]`
- `req_b`  in  `NUM_REQ*WIDTH`  operand b; same packing
- `resp_valid`  out  1  output slot holds a result
- `resp_ready`  in  1  consumer takes result this cycle
- `resp_sum`  out  `WIDTH+1`  registered `a+b` including carry
- `resp_id`  out  `ID_W`  index of the requester that produced `resp_sum`

## Operation
- Output slot has two states:
  - EMPTY: `resp_valid`=0.
  - FULL: `resp_valid`=1.
- `slot_free = !resp_valid || resp_ready`. This is the same-cycle drain-and-refill rule.
- Grant:
  - Only when `slot_free`.
  - Pick the first i with `req_valid[i]`=1, scanning from `ptr` upward with wrap modulo `NUM_REQ`.
  - `req_ready[i]`=1 for that i only. `req_ready` is combinational from `req_valid`, `ptr` and the slot state.
  - `req_ready` never depends combinationally on `req_a`/`req_b`.
- On grant to i:
  - `resp_sum` ← zero-extended `req_a[i]` + `req_b[i]` via the shared adder; no truncation.
  - `resp_id` ← i.
  - `resp_valid` ← 1.
  - `ptr` ← (i+1) mod `NUM_REQ`.
- No grant and `resp_ready`=1 in FULL: go to EMPTY; `resp_sum`/`resp_id` hold their last value.
- FULL and `resp_ready`=0: all outputs hold; `req_ready`=0.
- `ptr` changes only on a grant, so an idle requester does not lose its turn.
- Requester protocol:
  - Once `req_valid[i]`=1, the requester holds it and its operands until `req_ready[i]`.
  - Dropping valid early is illegal. The arbiter does not latch abandoned requests.
- Reset (asynchronous, any cycle including FULL): `resp_valid`=0, `resp_sum`=0, `resp_id`=0, `ptr`=0, stats counters=0. An in-flight result is discarded. First grant after reset deasserts favours requester 0.

## Timing
- Latency: grant cycle N → `resp_valid`=1 with result at cycle N+1.
- Throughput: one result per cycle while `resp_ready`=1 and some `req_valid` is set.
- Fairness: under continuous all-valid load, grants rotate 0,1,…,NUM_REQ-1,0… Worst-case wait is `NUM_REQ-1` grants.
- Combinational paths:
  - `resp_ready` → `req_ready`.
  - `req_valid` → `req_ready`.
- All outputs other than `req_ready` are registered.

## Configuration
- `ADDER_ARB_STATS_EN` defined adds outputs:
  - `stat_grants` (32 bits): total grants.
  - `stat_stalls` (32 bits): cycles with any `req_valid` set and `resp_valid && !resp_ready`.
- Both counters saturate at all-ones and reset to 0.
- Undefined: these ports and counters do not exist. Function and timing are otherwise identical.

## Test plan
- Single request: `req_valid`=0001, a=0x12, b=0x34, `resp_ready`=1 → `req_ready`=0001 same cycle; next cycle `resp_valid`=1, `resp_sum`=0x046, `resp_id`=0.
- Overflow: requester 2, a=0xFF, b=0xFF → `resp_sum`=0x1FE, `resp_id`=2.
- Round robin: `req_valid`=1111 held, `resp_ready`=1 → results on 4 consecutive cycles with `resp_id` 0,1,2,3. Then 0 again; no bubbles.
- Back-pressure: result in slot, `resp_ready`=0 for 5 cycles with `req_valid`=0110 → `req_ready`=0000 and `resp_sum`/`resp_id` stable. Raise `resp_ready` → requester 1 granted the same cycle, result next cycle.
- Reset mid-operation: slot FULL with `resp_id`=3, assert `rst` between clock edges → `resp_valid`/`resp_sum`/`resp_id` drop to 0 immediately. After release, `req_valid`=1111 grants requester 0 first.
- Random scoreboard: 1000 vectors with random `req_valid`/operands and random `resp_ready`. Check every sum against a+b keyed by id, in-order per requester, and never more than one `req_ready` bit set. With `ADDER_ARB_STATS_EN`, `stat_grants` equals the number of accepted requests.
